tx_gearbox_66to12: RTL and testbench

- Write-side feeder for the 12-bit TX clock-crossing FIFO in the 25G PCS transmit path.
- Accepts 66-bit encoded blocks from the scrambler/encoder stage and serialises them into a continuous stream of 12-bit words.
- Issues FIFO writes only when the FIFO's registered idle_wr permits.
- Runs entirely in the clk_wr domain. Two 66-bit blocks map exactly onto eleven 12-bit words.

---
 rtl/tx_gearbox_66to12.sv | 91 +++++++++
 tb/tb_tx_gearbox_66to12.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_gearbox_66to12.sv
// 66-to-12 bit TX gearbox feeding the write side of the clock-crossing FIFO.
// Accumulates encoded blocks and emits one FIFO word per cycle while idle_wr allows.
module tx_gearbox_66to12 #(
    parameter int IN_WIDTH   = 66,
    parameter int OUT_WIDTH  = 12,
    parameter int UCNT_WIDTH = 16
) (
    input  logic                  clk_wr,
    input  logic                  reset_n_wr,
    input  logic                  in_enable,
    input  logic                  blk_valid,
    input  logic [IN_WIDTH-1:0]   blk_data,
    output logic                  blk_ready,
    input  logic                  idle_wr,
    output logic                  en_wr,
    output logic [OUT_WIDTH-1:0]  data_wr,
    output logic                  started,
    output logic [UCNT_WIDTH-1:0] underrun_cnt
);

    localparam int BUF_W = IN_WIDTH + OUT_WIDTH;
    localparam int CNT_W = $clog2(BUF_W + 1);

    localparam logic [CNT_W-1:0] OUT_C = CNT_W'(OUT_WIDTH);
    localparam logic [CNT_W-1:0] IN_C  = CNT_W'(IN_WIDTH);

    // Valid bits live in acc_buf[cnt-1:0]; everything above cnt is kept zero
    logic [BUF_W-1:0] acc_buf;
    logic [BUF_W-1:0] acc_buf_d;
    logic [BUF_W-1:0] shifted;
    logic [BUF_W-1:0] blk_ext;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] base;

    logic acc;
    logic emit;
    logic starve;
    logic ucnt_full;

    assign blk_ready = in_enable & (cnt <= OUT_C);
    assign acc       = blk_valid & blk_ready;
    assign emit      = in_enable & idle_wr & (cnt >= OUT_C);
    assign starve    = in_enable & started & idle_wr & (cnt < OUT_C);
    assign ucnt_full = &underrun_cnt;

    // Drop the emitted word, then append an accepted block above the remainder
    always_comb begin
        shifted   = acc_buf;
        base      = cnt;
        blk_ext   = {{OUT_WIDTH{1'b0}}, blk_data};
        if (emit) begin
            shifted = acc_buf >> OUT_WIDTH;
            base    = cnt - OUT_C;
        end
        acc_buf_d = shifted;
        cnt_d     = base;
        if (acc) begin
            acc_buf_d = shifted | (blk_ext << base);
            cnt_d     = base + IN_C;
        end
    end

    // State and registered FIFO write port; in_enable low freezes all but en_wr
    always_ff @(posedge clk_wr or negedge reset_n_wr) begin
        if (!reset_n_wr) begin
            acc_buf      <= '0;
            cnt          <= '0;
            en_wr        <= 1'b0;
            data_wr      <= '0;
            started      <= 1'b0;
            underrun_cnt <= '0;
        end else if (in_enable) begin
            acc_buf <= acc_buf_d;
            cnt     <= cnt_d;
            en_wr   <= emit;
            if (emit) begin
                data_wr <= acc_buf[OUT_WIDTH-1:0];
            end
            if (acc) begin
                started <= 1'b1;
            end
            if (starve && !ucnt_full) begin
                underrun_cnt <= underrun_cnt + 1'b1;
            end
        end else begin
            en_wr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tx_gearbox_66to12.sv
// Directed bench for tx_gearbox_66to12.
// Bit-level scoreboard compares every FIFO write against the accepted blocks.
module tb_tx_gearbox_66to12;

    logic        clk_wr = 1'b0;
    logic        reset_n_wr;
    logic        in_enable;
    logic        blk_valid;
    logic [65:0] blk_data;
    logic        blk_ready;
    logic        idle_wr;
    logic        en_wr;
    logic [11:0] data_wr;
    logic        started;
    logic [15:0] underrun_cnt;

    int n_pass = 0;
    int n_tot  = 0;

    bit          exp_q[$];
    logic [11:0] wq[$];
    bit          last_acc;
    int          nwr;

    localparam logic [65:0] BLK_A = 66'h2_0123_4567_89AB_CDEF;
    localparam logic [65:0] BLK_B = 66'h1_FEDC_BA98_7654_3210;

    tx_gearbox_66to12 dut (
        .clk_wr       (clk_wr),
        .reset_n_wr   (reset_n_wr),
        .in_enable    (in_enable),
        .blk_valid    (blk_valid),
        .blk_data     (blk_data),
        .blk_ready    (blk_ready),
        .idle_wr      (idle_wr),
        .en_wr        (en_wr),
        .data_wr      (data_wr),
        .started      (started),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk_wr = ~clk_wr;

    task automatic chk(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock; inputs are sampled before the edge, outputs 1 time unit after
    task automatic tick();
        bit          a;
        bit          e_ok;
        logic [65:0] d;
        logic [11:0] w;
        a    = blk_valid && blk_ready && reset_n_wr;
        e_ok = idle_wr && in_enable && reset_n_wr;
        d    = blk_data;
        @(posedge clk_wr);
        #1;
        last_acc = a;
        if (a) begin
            for (int i = 0; i < 66; i++) exp_q.push_back(d[i]);
        end
        if (en_wr) begin
            nwr++;
            chk("gate", 128'(e_ok), 128'(1));
            chk("sb_level", 128'(exp_q.size() >= 12), 128'(1));
            w = '0;
            for (int i = 0; i < 12; i++) begin
                if (exp_q.size() > 0) w[i] = exp_q.pop_front();
            end
            chk("sb_word", 128'(data_wr), 128'(w));
            wq.push_back(data_wr);
        end
    endtask

    task automatic send_block(input logic [65:0] d);
        bit got;
        got       = 1'b0;
        blk_valid = 1'b1;
        blk_data  = d;
        for (int i = 0; i < 200 && !got; i++) begin
            tick();
            got = last_acc;
        end
        chk("accept", 128'(got), 128'(1));
        blk_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        blk_valid = 1'b0;
        idle_wr   = 1'b1;
        repeat (n) tick();
    endtask

    initial begin
        logic [15:0] u0;
        logic [6:0]  c0;
        logic [65:0] d;
        bit          hit;

        reset_n_wr = 1'b0;
        in_enable  = 1'b1;
        blk_valid  = 1'b0;
        blk_data   = '0;
        idle_wr    = 1'b1;
        nwr        = 0;
        #2;
        chk("rst_en_wr", 128'(en_wr), 128'(0));
        chk("rst_data", 128'(data_wr), 128'(0));
        chk("rst_started", 128'(started), 128'(0));
        chk("rst_ucnt", 128'(underrun_cnt), 128'(0));
        repeat (2) @(posedge clk_wr);
        #1;
        reset_n_wr = 1'b1;
        chk("rst_ready", 128'(blk_ready), 128'(1));
        chk("rst_cnt", 128'(dut.cnt), 128'(0));

        // Steady pair A then B
        send_block(BLK_A);
        chk("started", 128'(started), 128'(1));
        send_block(BLK_B);
        drain(12);
        chk("pair_words", 128'(wq.size()), 128'(11));
        chk("word0", 128'(wq[0]), 128'(12'hDEF));
        chk("word5", 128'(wq[5]), 128'(12'h420));
        chk("word10", 128'(wq[10]), 128'(12'h7FB));
        chk("pair_cnt", 128'(dut.cnt), 128'(0));

        // Back-pressure at cnt=30
        send_block(66'h3_5555_AAAA_0F0F_F0F0);
        hit = (dut.cnt == 7'd30);
        for (int i = 0; i < 20 && !hit; i++) begin
            tick();
            hit = (dut.cnt == 7'd30);
        end
        chk("bp_reach30", 128'(hit), 128'(1));
        idle_wr = 1'b0;
        repeat (5) begin
            tick();
            chk("bp_en_low", 128'(en_wr), 128'(0));
            chk("bp_ready_low", 128'(blk_ready), 128'(0));
        end
        chk("bp_cnt", 128'(dut.cnt), 128'(30));
        idle_wr = 1'b1;
        send_block(66'h0_1357_9BDF_2468_ACE0);
        drain(14);
        chk("bp_cnt0", 128'(dut.cnt), 128'(0));
        chk("bp_sb_empty", 128'(exp_q.size()), 128'(0));

        // in_enable low mid-pair
        send_block(66'h2_DEAD_BEEF_CAFE_F00D);
        tick();
        tick();
        in_enable = 1'b0;
        blk_valid = 1'b1;
        blk_data  = 66'h1_0BAD_F00D_1234_5678;
        u0 = underrun_cnt;
        tick();
        c0 = dut.cnt;
        nwr = 0;
        repeat (9) begin
            tick();
            chk("ie_ready_low", 128'(blk_ready), 128'(0));
        end
        chk("ie_no_write", 128'(nwr), 128'(0));
        chk("ie_cnt_hold", 128'(dut.cnt), 128'(c0));
        chk("ie_ucnt_hold", 128'(underrun_cnt), 128'(u0));
        in_enable = 1'b1;
        send_block(66'h1_0BAD_F00D_1234_5678);
        drain(14);
        chk("ie_cnt0", 128'(dut.cnt), 128'(0));
        chk("ie_sb_empty", 128'(exp_q.size()), 128'(0));

        // Starvation and counter saturation
        send_block(66'h3_FFFF_0000_FFFF_0000);
        nwr = 0;
        drain(8);
        chk("st_writes", 128'(nwr), 128'(5));
        chk("st_cnt", 128'(dut.cnt), 128'(6));
        u0 = underrun_cnt;
        drain(10);
        chk("st_ucnt_inc", 128'(underrun_cnt), 128'(u0 + 16'd10));
        drain(65540);
        chk("st_ucnt_sat", 128'(underrun_cnt), 128'(16'hFFFF));

        // Accept and emit in the same cycle at cnt=12
        send_block(66'h0_AAAA_5555_CCCC_3333);
        blk_valid = 1'b1;
        blk_data  = 66'h2_7777_8888_9999_1111;
        hit = (dut.cnt == 7'd12);
        for (int i = 0; i < 20 && !hit; i++) begin
            tick();
            hit = (dut.cnt == 7'd12);
        end
        chk("ae_reach12", 128'(hit), 128'(1));
        chk("ae_ready", 128'(blk_ready), 128'(1));
        tick();
        chk("ae_acc", 128'(last_acc), 128'(1));
        chk("ae_en", 128'(en_wr), 128'(1));
        chk("ae_cnt", 128'(dut.cnt), 128'(66));
        drain(8);

        // Random back-pressure over 1000 blocks
        for (int b = 0; b < 1000; b++) begin
            d[31:0]   = $urandom();
            d[63:32]  = $urandom();
            d[65:64]  = 2'($urandom_range(0, 3));
            blk_valid = 1'b1;
            blk_data  = d;
            hit       = 1'b0;
            for (int i = 0; i < 200 && !hit; i++) begin
                idle_wr = ($urandom_range(0, 3) != 0);
                tick();
                hit = last_acc;
            end
            chk("rnd_accept", 128'(hit), 128'(1));
        end
        drain(20);
        chk("rnd_residue", 128'(dut.cnt), 128'(exp_q.size()));

        // Asynchronous reset mid-stream, then realignment
        send_block(66'h1_2222_3333_4444_5555);
        tick();
        tick();
        #3;
        reset_n_wr = 1'b0;
        #1;
        chk("ar_en", 128'(en_wr), 128'(0));
        chk("ar_data", 128'(data_wr), 128'(0));
        chk("ar_cnt", 128'(dut.cnt), 128'(0));
        chk("ar_ucnt", 128'(underrun_cnt), 128'(0));
        chk("ar_started", 128'(started), 128'(0));
        exp_q.delete();
        wq.delete();
        tick();
        reset_n_wr = 1'b1;
        chk("ar_ready", 128'(blk_ready), 128'(1));
        send_block(BLK_A);
        send_block(BLK_B);
        drain(12);
        chk("ar_words", 128'(wq.size()), 128'(11));
        chk("ar_word0", 128'(wq[0]), 128'(12'hDEF));
        chk("ar_word10", 128'(wq[10]), 128'(12'h7FB));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
